// File: rtl/telemetry_formatter.sv
`default_nettype none
// ============================================================================
// Module   : telemetry_formatter
// Purpose  : Converts per-frame telemetry values to labelled, right-aligned
//            decimal ASCII rows for the VGA text overlay. Double-buffered so
//            the display only changes on a vertical-blanking tick.
// Revision : 1.0 - initial release
// ============================================================================
module telemetry_formatter #(
  parameter  int NUM_ROWS  = 4,
  parameter  int LABEL_LEN = 3,
  parameter  int DIGITS    = 5,
  parameter  int VALUE_W   = 16,
  localparam int NUM_COLS  = LABEL_LEN + DIGITS
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    frame_tick,
  input  logic                                    enable,
  input  logic [NUM_ROWS-1:0][VALUE_W-1:0]        values,
  input  logic [NUM_ROWS-1:0][LABEL_LEN-1:0][7:0] labels,
  input  logic                                    overrun_clr,
  output logic [NUM_ROWS-1:0][NUM_COLS-1:0][7:0]  chars,
  output logic                                    busy,
  output logic                                    overrun
);

  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int CNT_W = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam int BCD_W = DIGITS * 4;
  localparam logic [63:0] MAX_DEC = 64'(10 ** DIGITS) - 64'd1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_READY = 2'd3;

  localparam logic [NUM_ROWS-1:0][NUM_COLS-1:0][7:0] ALL_SPACES =
    {(NUM_ROWS * NUM_COLS){8'h20}};

  logic [1:0]                                 state_q, state_d;
  logic [ROW_W-1:0]                           row_q, row_d;
  logic [CNT_W-1:0]                           cnt_q, cnt_d;
  logic [BCD_W-1:0]                           bcd_q, bcd_d;
  logic [VALUE_W-1:0]                         shreg_q, shreg_d;
  logic [NUM_ROWS-1:0][VALUE_W-1:0]           values_q;
  logic [NUM_ROWS-1:0][LABEL_LEN-1:0][7:0]    labels_q;
  logic [NUM_ROWS-1:0]                        ovf_q;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][7:0]     shadow_q, shadow_d;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0][7:0]     chars_q, chars_d;
  logic                                       overrun_q, overrun_d;

  logic [NUM_ROWS-1:0]                        ovf_now;
  logic [BCD_W-1:0]                           bcd_adj;
  logic [NUM_COLS-1:0][7:0]                   row_text;
  logic [3:0]                                 nib;
  logic                                       lead;
  logic                                       busy_w;
  logic                                       tick_acc;
  logic                                       tick_busy;

  assign busy_w    = (state_q == S_SHIFT) || (state_q == S_WRITE);
  assign tick_acc  = frame_tick && enable && !busy_w;
  assign tick_busy = frame_tick && enable && busy_w;

  // Overflow is decided on the raw snapshot, since the BCD register cannot hold it
  generate
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_ovf
      assign ovf_now[r] = 64'(values[r]) > MAX_DEC;
    end
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      assign bcd_adj[d*4 +: 4] = (bcd_q[d*4 +: 4] >= 4'd5) ?
                                 (bcd_q[d*4 +: 4] + 4'd3) : bcd_q[d*4 +: 4];
    end
  endgenerate

  always_comb begin
    row_text = '0;
    lead     = 1'b1;
    nib      = 4'd0;
    for (int c = 0; c < LABEL_LEN; c++) begin
      row_text[c] = labels_q[row_q][c];
    end
    for (int k = 0; k < DIGITS; k++) begin
      nib = bcd_q[(DIGITS-1-k)*4 +: 4];
      if ((nib != 4'd0) || (k == DIGITS-1)) begin
        lead = 1'b0;
      end
      if (ovf_q[row_q]) begin
        row_text[LABEL_LEN+k] = 8'h23;
      end else if (lead) begin
        row_text[LABEL_LEN+k] = 8'h20;
      end else begin
        row_text[LABEL_LEN+k] = {4'h3, nib};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    shreg_d   = shreg_q;
    shadow_d  = shadow_q;
    chars_d   = chars_q;
    overrun_d = overrun_q;

    case (state_q)
      S_IDLE, S_READY: begin
        if (tick_acc) begin
          if (state_q == S_READY) begin
            chars_d = shadow_q;
          end
          state_d = S_SHIFT;
          row_d   = '0;
          cnt_d   = '0;
          bcd_d   = '0;
          shreg_d = values[0];
        end
      end
      S_SHIFT: begin
        {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(VALUE_W - 1)) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        shadow_d[row_q] = row_text;
        cnt_d = '0;
        bcd_d = '0;
        if (row_q == ROW_W'(NUM_ROWS - 1)) begin
          state_d = S_READY;
        end else begin
          row_d   = row_q + ROW_W'(1);
          shreg_d = values_q[row_q + ROW_W'(1)];
          state_d = S_SHIFT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A late tick must stay visible even if software clears in the same cycle
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (tick_busy) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      shreg_q   <= '0;
      values_q  <= '0;
      labels_q  <= '0;
      ovf_q     <= '0;
      shadow_q  <= ALL_SPACES;
      chars_q   <= ALL_SPACES;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      shreg_q   <= shreg_d;
      shadow_q  <= shadow_d;
      chars_q   <= chars_d;
      overrun_q <= overrun_d;
      if (tick_acc) begin
        values_q <= values;
        labels_q <= labels;
        ovf_q    <= ovf_now;
      end
    end
  end

  assign chars   = chars_q;
  assign busy    = busy_w;
  assign overrun = overrun_q;

endmodule
`default_nettype wire
